// File: rtl/lcd_msg_seq_if.sv
// lcd_msg_seq_if: bundle of every signal between the message sequencer and
// its neighbours (host control, character ROM, serial LCD controller).
//   master : the sequencer side (drives requests, status, ROM address)
//   slave  : the environment side (drives start/update, acks, ROM data)
// Signals:
//   start, update          host requests
//   busy, done, err        sequencer status
//   initlcd                controller init strobe
//   resetlcd/lcdreset      reset request/ack
//   clearlcd/lcdclear      clear request/ack
//   cmdlcd/lcdcmd          command request/ack
//   datalcd/lcddata        data request/ack
//   lcddatin[7:0]          command or character byte to the controller
//   charaddr[AW-1:0]       character ROM address
//   chardata[7:0]          character ROM data
interface lcd_msg_seq_if #(
  parameter int AW = 5
);
  logic          start;
  logic          update;
  logic          busy;
  logic          done;
  logic          err;
  logic          initlcd;
  logic          resetlcd;
  logic          lcdreset;
  logic          clearlcd;
  logic          lcdclear;
  logic          cmdlcd;
  logic          lcdcmd;
  logic          datalcd;
  logic          lcddata;
  logic [7:0]    lcddatin;
  logic [AW-1:0] charaddr;
  logic [7:0]    chardata;

  modport master (
    input  start, update, lcdreset, lcdclear, lcdcmd, lcddata, chardata,
    output busy, done, err, initlcd, resetlcd, clearlcd, cmdlcd, datalcd,
           lcddatin, charaddr
  );

  modport slave (
    output start, update, lcdreset, lcdclear, lcdcmd, lcddata, chardata,
    input  busy, done, err, initlcd, resetlcd, clearlcd, cmdlcd, datalcd,
           lcddatin, charaddr
  );
endinterface

// File: rtl/lcd_msg_seq.sv
// lcd_msg_seq: multi-line message sequencer for the serial character LCD.
// A start request runs reset, clear, then for every line a cursor-position
// command followed by MSGLEN characters fetched from the character ROM.
// An update request skips reset and clear and rewrites all lines.
// Every transaction is preceded by one cycle of initlcd high and one low;
// each request is held until its ack is sampled, then stays low one cycle.
//
// Ports:
//   lcdclk  sole clock, rising edge
//   reset   asynchronous active-high reset
//   bus     lcd_msg_seq_if.master (control, controller handshakes, ROM)
//
// Optional feature: define LCDSEQ_TIMEOUT_EN to add a request watchdog.
// A request left unacknowledged for TIMEOUT cycles is dropped and the FSM
// parks in ERR (err=1) until start or reset. Without it err stays 0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | after reset, waiting for start/update
// PRE_RST  | init strobe ahead of the reset transaction
// RST      | resetlcd held until lcdreset, then one low cycle
// PRE_CLR  | init strobe ahead of the clear transaction
// CLR      | clearlcd held until lcdclear, then one low cycle
// PRE_POS  | init strobe ahead of the cursor command (0x80 / 0xC0)
// POS      | cmdlcd held until lcdcmd, then one low cycle
// FETCH    | present the next character address to the ROM
// ROMW     | ROM access cycle
// PRE_DATA | init strobe; ROM byte latched into lcddatin at its end
// DATA     | datalcd held until lcddata
// NEXT     | datalcd low; advance character / line or finish
// DONE     | sequence complete, done=1
// ERR      | watchdog expired, err=1 (only with LCDSEQ_TIMEOUT_EN)
module lcd_msg_seq #(
  parameter int MSGLEN  = 16,
  parameter int NLINES  = 2,
  parameter int TIMEOUT = 1000,
  parameter int AW      = $clog2(MSGLEN*NLINES)
) (
  input  logic          lcdclk,
  input  logic          reset,
  lcd_msg_seq_if.master bus
);
  localparam int            CW     = (MSGLEN > 1) ? $clog2(MSGLEN) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(MSGLEN-1);
  localparam logic          L_LAST = 1'(NLINES-1);

  typedef enum logic [3:0] {
    IDLE, PRE_RST, RST, PRE_CLR, CLR, PRE_POS, POS,
    FETCH, ROMW, PRE_DATA, DATA, NEXT, DONE, ERR
  } state_t;

  state_t        state;
  logic          pre_lo;
  logic          ack_seen;
  logic [CW-1:0] cidx;
  logic          line;
  logic [AW-1:0] addr;

  logic req_any;
  logic req_ack;
  logic tmo_hit;
  logic accept_ok;
  logic go_full;
  logic go_upd;

  assign req_any = bus.resetlcd | bus.clearlcd | bus.cmdlcd | bus.datalcd;
  assign req_ack = (bus.resetlcd & bus.lcdreset) | (bus.clearlcd & bus.lcdclear) |
                   (bus.cmdlcd & bus.lcdcmd) | (bus.datalcd & bus.lcddata);

  assign accept_ok = (state == IDLE) || (state == DONE) || (state == ERR);
  assign go_full   = accept_ok && bus.start;
  // update never restarts from ERR; start has priority when both are high
  assign go_upd    = accept_ok && bus.update && !bus.start && (state != ERR);

`ifdef LCDSEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0] tmo;

  // Reloaded whenever no request is up, so it counts the cycles the
  // current request has been high; expiry lands TIMEOUT edges after it rose.
  always_ff @(posedge lcdclk or posedge reset) begin
    if (reset) begin
      tmo <= TW'(TIMEOUT-1);
    end else if (!req_any) begin
      tmo <= TW'(TIMEOUT-1);
    end else if (tmo != '0) begin
      tmo <= tmo - TW'(1);
    end
  end

  assign tmo_hit = req_any && (tmo == '0);
`else
  // No watchdog: TIMEOUT is inert and this compare folds to constant 0.
  assign tmo_hit = (TIMEOUT < 0);
`endif

  always_ff @(posedge lcdclk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pre_lo       <= 1'b0;
      ack_seen     <= 1'b0;
      cidx         <= '0;
      line         <= 1'b0;
      addr         <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      bus.initlcd  <= 1'b0;
      bus.resetlcd <= 1'b0;
      bus.clearlcd <= 1'b0;
      bus.cmdlcd   <= 1'b0;
      bus.datalcd  <= 1'b0;
      bus.lcddatin <= '0;
      bus.charaddr <= '0;
    end else if (go_full || go_upd) begin
      state       <= go_full ? PRE_RST : PRE_POS;
      pre_lo      <= 1'b0;
      ack_seen    <= 1'b0;
      cidx        <= '0;
      line        <= 1'b0;
      addr        <= '0;
      bus.busy    <= 1'b1;
      bus.done    <= 1'b0;
      bus.err     <= 1'b0;
      bus.initlcd <= 1'b1;
    end else if (tmo_hit && !req_ack) begin
      state        <= ERR;
      bus.busy     <= 1'b0;
      bus.err      <= 1'b1;
      bus.resetlcd <= 1'b0;
      bus.clearlcd <= 1'b0;
      bus.cmdlcd   <= 1'b0;
      bus.datalcd  <= 1'b0;
    end else begin
      case (state)
        PRE_RST: begin
          bus.initlcd <= 1'b0;
          pre_lo      <= 1'b1;
          if (pre_lo) begin
            pre_lo       <= 1'b0;
            state        <= RST;
            bus.resetlcd <= 1'b1;
          end
        end
        RST: begin
          if (!ack_seen) begin
            if (bus.lcdreset) begin
              bus.resetlcd <= 1'b0;
              ack_seen     <= 1'b1;
            end
          end else begin
            ack_seen    <= 1'b0;
            state       <= PRE_CLR;
            bus.initlcd <= 1'b1;
          end
        end
        PRE_CLR: begin
          bus.initlcd <= 1'b0;
          pre_lo      <= 1'b1;
          if (pre_lo) begin
            pre_lo       <= 1'b0;
            state        <= CLR;
            bus.clearlcd <= 1'b1;
          end
        end
        CLR: begin
          if (!ack_seen) begin
            if (bus.lcdclear) begin
              bus.clearlcd <= 1'b0;
              ack_seen     <= 1'b1;
            end
          end else begin
            ack_seen    <= 1'b0;
            state       <= PRE_POS;
            bus.initlcd <= 1'b1;
          end
        end
        PRE_POS: begin
          bus.initlcd <= 1'b0;
          pre_lo      <= 1'b1;
          if (pre_lo) begin
            pre_lo       <= 1'b0;
            state        <= POS;
            bus.lcddatin <= line ? 8'hC0 : 8'h80;
            bus.cmdlcd   <= 1'b1;
          end
        end
        POS: begin
          if (!ack_seen) begin
            if (bus.lcdcmd) begin
              bus.cmdlcd <= 1'b0;
              ack_seen   <= 1'b1;
            end
          end else begin
            ack_seen <= 1'b0;
            state    <= FETCH;
          end
        end
        FETCH: begin
          bus.charaddr <= addr;
          state        <= ROMW;
        end
        ROMW: begin
          state       <= PRE_DATA;
          bus.initlcd <= 1'b1;
        end
        PRE_DATA: begin
          bus.initlcd <= 1'b0;
          pre_lo      <= 1'b1;
          if (pre_lo) begin
            // byte and request are registered together, so the byte is
            // already stable when datalcd rises
            pre_lo       <= 1'b0;
            state        <= DATA;
            bus.lcddatin <= bus.chardata;
            bus.datalcd  <= 1'b1;
          end
        end
        DATA: begin
          if (bus.lcddata) begin
            bus.datalcd <= 1'b0;
            state       <= NEXT;
          end
        end
        NEXT: begin
          if (cidx == C_LAST) begin
            cidx <= '0;
            if (line == L_LAST) begin
              line     <= 1'b0;
              addr     <= '0;
              state    <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end else begin
              line        <= 1'b1;
              addr        <= addr + AW'(1);
              state       <= PRE_POS;
              bus.initlcd <= 1'b1;
            end
          end else begin
            cidx  <= cidx + CW'(1);
            addr  <= addr + AW'(1);
            state <= FETCH;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_msg_seq.sv
module tb_lcd_msg_seq;
  logic lcdclk;
  logic reset;

  lcd_msg_seq_if #(.AW(3)) bus0 ();
  lcd_msg_seq_if #(.AW(2)) bus1 ();

  lcd_msg_seq #(.MSGLEN(4), .NLINES(2), .TIMEOUT(16), .AW(3)) u_dut (
    .lcdclk (lcdclk),
    .reset  (reset),
    .bus    (bus0)
  );

  lcd_msg_seq #(.MSGLEN(3), .NLINES(1), .TIMEOUT(16), .AW(2)) u_dut1 (
    .lcdclk (lcdclk),
    .reset  (reset),
    .bus    (bus1)
  );

  typedef struct {
    int         kind;   // 0 reset, 1 clear, 2 cmd, 3 data
    logic [7:0] b;
    int         addr;
  } ev_t;

  typedef struct {
    bit start;
    bit update;
    int lat;
    int mid;
    int n_rst;
    int n_clr;
    int n_cmd;
    int n_data;
    int cycles;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  int stab_err = 0;
  int lat = 1;
  logic [3:0] ack_en = 4'hF;
  logic [7:0] rom [8];

  ev_t log0[$];
  ev_t log1[$];
  ev_t exp_q[$];

  initial begin
    lcdclk = 1'b0;
    forever #10 lcdclk = ~lcdclk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Controller model: ack rises lat negedges after the request is seen
  // and is held until the request drops.
  logic [3:0]  ack0 = '0, ack1 = '0;
  logic [15:0] cnt0 = '0, cnt1 = '0;

  function automatic void resp(input logic [3:0] r, input logic [3:0] a_in,
                               input logic [15:0] c_in, output logic [3:0] a_out,
                               output logic [15:0] c_out);
    a_out = a_in;
    c_out = c_in;
    for (int ch = 0; ch < 4; ch++) begin
      if (reset || !r[ch]) begin
        a_out[ch] = 1'b0;
        c_out[ch*4 +: 4] = 4'd0;
      end else if (int'(c_in[ch*4 +: 4]) < lat) begin
        c_out[ch*4 +: 4] = c_in[ch*4 +: 4] + 4'd1;
      end else if (ack_en[ch]) begin
        a_out[ch] = 1'b1;
      end
    end
  endfunction

  always @(negedge lcdclk) begin
    logic [3:0]  a;
    logic [15:0] c;
    resp({bus0.datalcd, bus0.cmdlcd, bus0.clearlcd, bus0.resetlcd}, ack0, cnt0, a, c);
    ack0 = a;
    cnt0 = c;
    resp({bus1.datalcd, bus1.cmdlcd, bus1.clearlcd, bus1.resetlcd}, ack1, cnt1, a, c);
    ack1 = a;
    cnt1 = c;
    bus0.chardata = rom[bus0.charaddr];
    bus1.chardata = rom[{1'b0, bus1.charaddr}];
  end

  assign {bus0.lcddata, bus0.lcdcmd, bus0.lcdclear, bus0.lcdreset} = ack0;
  assign {bus1.lcddata, bus1.lcdcmd, bus1.lcdclear, bus1.lcdreset} = ack1;

  // Transaction monitor: log every request rising edge with its byte/address.
  logic [3:0] p0 = '0, p1 = '0;
  logic [7:0] pd0 = '0;
  logic [2:0] pa0 = '0;

  always @(negedge lcdclk) begin
    logic [3:0] r;
    r = {bus0.datalcd, bus0.cmdlcd, bus0.clearlcd, bus0.resetlcd};
    if (r[0] && !p0[0]) log0.push_back(ev_t'{0, 8'h00, 0});
    if (r[1] && !p0[1]) log0.push_back(ev_t'{1, 8'h00, 0});
    if (r[2] && !p0[2]) log0.push_back(ev_t'{2, bus0.lcddatin, 0});
    if (r[3] && !p0[3]) log0.push_back(ev_t'{3, bus0.lcddatin, int'(bus0.charaddr)});
    if ((r & p0) != 4'd0 && bus0.lcddatin != pd0) stab_err++;
    if (r[3] && p0[3] && bus0.charaddr != pa0) stab_err++;
    p0  = r;
    pd0 = bus0.lcddatin;
    pa0 = bus0.charaddr;
    r = {bus1.datalcd, bus1.cmdlcd, bus1.clearlcd, bus1.resetlcd};
    if (r[0] && !p1[0]) log1.push_back(ev_t'{0, 8'h00, 0});
    if (r[1] && !p1[1]) log1.push_back(ev_t'{1, 8'h00, 0});
    if (r[2] && !p1[2]) log1.push_back(ev_t'{2, bus1.lcddatin, 0});
    if (r[3] && !p1[3]) log1.push_back(ev_t'{3, bus1.lcddatin, int'(bus1.charaddr)});
    p1 = r;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic build_exp(input int msglen, input int nlines, input bit full);
    exp_q.delete();
    if (full) begin
      exp_q.push_back(ev_t'{0, 8'h00, 0});
      exp_q.push_back(ev_t'{1, 8'h00, 0});
    end
    for (int l = 0; l < nlines; l++) begin
      exp_q.push_back(ev_t'{2, (l == 0) ? 8'h80 : 8'hC0, 0});
      for (int c = 0; c < msglen; c++)
        exp_q.push_back(ev_t'{3, 8'(8'h61 + l*msglen + c), l*msglen + c});
    end
  endtask

  task automatic cmp_stream(input string tag, input ev_t got[$]);
    chk({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      chk($sformatf("%s_kind%0d", tag, i), got[i].kind, exp_q[i].kind);
      chk($sformatf("%s_byte%0d", tag, i), int'(got[i].b), int'(exp_q[i].b));
      chk($sformatf("%s_addr%0d", tag, i), got[i].addr, exp_q[i].addr);
    end
  endtask

  function automatic int count_kind(input ev_t q[$], input int k);
    int n = 0;
    foreach (q[i]) if (q[i].kind == k) n++;
    return n;
  endfunction

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_busy"}, bus0.busy, 0);
    chk({tag, "_done"}, bus0.done, 0);
    chk({tag, "_err"}, bus0.err, 0);
    chk({tag, "_initlcd"}, bus0.initlcd, 0);
    chk({tag, "_reqs"}, {bus0.resetlcd, bus0.clearlcd, bus0.cmdlcd, bus0.datalcd}, 0);
    chk({tag, "_lcddatin"}, bus0.lcddatin, 0);
    chk({tag, "_charaddr"}, bus0.charaddr, 0);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int  cyc;
    bit  held_ok;
    bit  got;
    lat = v.lat;
    @(negedge lcdclk);
    log0.delete();
    bus0.start  = v.start;
    bus0.update = v.update;
    @(posedge lcdclk);
    #1;
    bus0.start  = 1'b0;
    bus0.update = 1'b0;
    chk({tag, "_busy_rise"}, bus0.busy, 1);
    chk({tag, "_initlcd_first"}, bus0.initlcd, 1);
    chk({tag, "_done_clr"}, bus0.done, 0);
    chk({tag, "_err_clr"}, bus0.err, 0);
    held_ok = 1'b1;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 2000) begin
      @(posedge lcdclk);
      #1;
      cyc++;
      bus0.start  = (v.mid != 0) && (cyc == v.mid);
      bus0.update = (v.mid != 0) && (cyc == v.mid);
      if (bus0.done) got = 1'b1;
      else if (!bus0.busy) held_ok = 1'b0;
    end
    bus0.start  = 1'b0;
    bus0.update = 1'b0;
    chk({tag, "_cycles"}, cyc, v.cycles);
    chk({tag, "_busy_held"}, held_ok, 1);
    chk({tag, "_done"}, bus0.done, 1);
    chk({tag, "_busy_fall"}, bus0.busy, 0);
    chk({tag, "_err_low"}, bus0.err, 0);
    chk({tag, "_n_rst"}, count_kind(log0, 0), v.n_rst);
    chk({tag, "_n_clr"}, count_kind(log0, 1), v.n_clr);
    chk({tag, "_n_cmd"}, count_kind(log0, 2), v.n_cmd);
    chk({tag, "_n_data"}, count_kind(log0, 3), v.n_data);
    build_exp(4, 2, v.start);
    cmp_stream(tag, log0);
  endtask

  initial begin
    vec_t vecs[6];
    int   k;
    // start  upd lat mid rst clr cmd data cycles
    vecs[0] = '{1'b1, 1'b1, 1, 0,  1, 1, 2, 8, 76};
    vecs[1] = '{1'b0, 1'b1, 3, 0,  0, 0, 2, 8, 86};
    vecs[2] = '{1'b1, 1'b0, 3, 0,  1, 1, 2, 8, 100};
    vecs[3] = '{1'b0, 1'b1, 0, 0,  0, 0, 2, 8, 56};
    vecs[4] = '{1'b1, 1'b0, 2, 20, 1, 1, 2, 8, 88};
    vecs[5] = '{1'b0, 1'b1, 4, 30, 0, 0, 2, 8, 96};

    for (int i = 0; i < 8; i++) rom[i] = 8'(8'h61 + i);

    reset       = 1'b1;
    bus0.start  = 1'b0;
    bus0.update = 1'b0;
    bus1.start  = 1'b0;
    bus1.update = 1'b0;
    repeat (3) @(posedge lcdclk);
    #1;
    chk_outs_zero("por");
    chk("por_busy1", bus1.busy, 0);
    @(negedge lcdclk);
    reset = 1'b0;
    repeat (2) @(negedge lcdclk);

    for (int i = 0; i < 6; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // reset while datalcd is high on the third character
    lat = 3;
    @(negedge lcdclk);
    bus0.start = 1'b1;
    @(posedge lcdclk);
    #1;
    bus0.start = 1'b0;
    k = 0;
    while (!(bus0.datalcd && bus0.charaddr == 3'd2) && k < 500) begin
      @(negedge lcdclk);
      k++;
    end
    chk("mid_reach_char2", (bus0.datalcd && bus0.charaddr == 3'd2) ? 1 : 0, 1);
    reset = 1'b1;
    #1;
    chk_outs_zero("mid_rst");
    @(negedge lcdclk);
    reset = 1'b0;
    run_vec("after_rst", vecs[2]);

    // single-line instance: MSGLEN=3, NLINES=1
    lat = 1;
    @(negedge lcdclk);
    log1.delete();
    bus1.start = 1'b1;
    @(posedge lcdclk);
    #1;
    bus1.start = 1'b0;
    k = 0;
    while (!bus1.done && k < 500) begin
      @(posedge lcdclk);
      #1;
      k++;
    end
    chk("one_line_cycles", k, 36);
    chk("one_line_done", bus1.done, 1);
    chk("one_line_busy", bus1.busy, 0);
    build_exp(3, 1, 1'b1);
    cmp_stream("one_line", log1);

`ifdef LCDSEQ_TIMEOUT_EN
    // lcdclear never acks: clear request drops TIMEOUT=16 cycles after rising
    ack_en = 4'b1101;
    lat = 1;
    @(negedge lcdclk);
    log0.delete();
    bus0.start = 1'b1;
    @(posedge lcdclk);
    #1;
    bus0.start = 1'b0;
    k = 0;
    while (!bus0.clearlcd && k < 200) begin
      @(posedge lcdclk);
      #1;
      k++;
    end
    chk("tmo_clr_rise", bus0.clearlcd, 1);
    k = 0;
    while (!bus0.err && k < 100) begin
      @(posedge lcdclk);
      #1;
      k++;
    end
    chk("tmo_cycles", k, 16);
    chk("tmo_clr_drop", bus0.clearlcd, 0);
    chk("tmo_busy", bus0.busy, 0);
    @(negedge lcdclk);
    bus0.update = 1'b1;
    @(negedge lcdclk);
    bus0.update = 1'b0;
    repeat (4) @(negedge lcdclk);
    chk("tmo_upd_err", bus0.err, 1);
    chk("tmo_upd_busy", bus0.busy, 0);
    chk("tmo_upd_events", log0.size(), 2);
    ack_en = 4'hF;
    run_vec("tmo_restart", vecs[0]);
`endif

    chk("lcddatin_stable", stab_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
